// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with a two-entry skid buffer,
// synchronous flush and NOP bubble insertion.
//   clk        clock, all state updates on posedge
//   rst_n      synchronous active-low reset
//   in_valid   upstream offers in_data this cycle
//   in_ready   stage can accept (registered, low only when both entries are held)
//   in_data    upstream payload
//   flush      squash every held payload
//   out_valid  out_data is a live payload
//   out_ready  downstream consumes (0 = stall)
//   out_data   payload to next stage, NOP_VALUE when out_valid=0
//   occupancy  number of entries held (0..2)
module pipe_stage_skid #(
    parameter int              DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    // Encoded as {skid_valid, main_valid} so the handshake outputs are bare state bits.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] main_data, main_d;
    logic [DATA_W-1:0] skid_data, skid_d;
    logic [1:0]        occ_d;
    logic              accept, drain;

    assign out_valid = state[0];
    assign in_ready  = !state[1];
    assign out_data  = main_data;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_d = state;
        main_d  = main_data;
        skid_d  = skid_data;
        if (flush) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_d = HALF;
                    main_d  = in_data;
                end
                HALF: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (drain) begin
                        // Emptying: main falls back to the bubble value.
                        state_d = EMPTY;
                        main_d  = NOP_VALUE;
                    end
                end
                FULL: if (drain) begin
                    state_d = HALF;
                    main_d  = skid_data;
                    skid_d  = NOP_VALUE;
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
        occ_d = state_d == FULL ? 2'd2 : state_d == HALF ? 2'd1 : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_data <= NOP_VALUE;
            skid_data <= NOP_VALUE;
            occupancy <= 2'd0;
        end else begin
            state     <= state_d;
            main_data <= main_d;
            skid_data <= skid_d;
            occupancy <= occ_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed self-checking bench for pipe_stage_skid.
module tb_pipe_stage_skid;
    localparam int          W   = 64;
    localparam logic [W-1:0] NOP = 64'h13;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   occupancy;
    int           checks = 0;
    int           passed = 0;

    pipe_stage_skid #(.DATA_W(W), .NOP_VALUE(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    // Observed and expected are packed as {out_valid, in_ready, occupancy, out_data}.
    task automatic test_reset;
        logic [W+3:0] exp_v;
        rst_n = 1'b0; in_valid = 1'b1; in_data = 64'hAAAA; flush = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        exp_v = {1'b0, 1'b1, 2'd0, NOP};
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== exp_v)
            $display("FAIL reset: got %h want %h", {out_valid, in_ready, occupancy, out_data}, exp_v);
        else passed++;
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== exp_v)
            $display("FAIL reset_idle: got %h want %h", {out_valid, in_ready, occupancy, out_data}, exp_v);
        else passed++;
    endtask

    task automatic test_streaming;
        logic [W+3:0] exp_v;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(W'(i));
            exp_v = {1'b1, 1'b1, 2'd1, W'(i)};
            checks++;
            if ({out_valid, in_ready, occupancy, out_data} !== exp_v)
                $display("FAIL stream_%0d: got %h want %h", i, {out_valid, in_ready, occupancy, out_data}, exp_v);
            else passed++;
        end
        in_valid = 1'b0;
        tick();
        exp_v = {1'b0, 1'b1, 2'd0, NOP};
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== exp_v)
            $display("FAIL bubble: got %h want %h", {out_valid, in_ready, occupancy, out_data}, exp_v);
        else passed++;
    endtask

    task automatic test_stall;
        logic [W+3:0] exp_v [6];
        out_ready = 1'b0;
        exp_v[0] = {1'b1, 1'b1, 2'd1, 64'h10};
        exp_v[1] = {1'b1, 1'b0, 2'd2, 64'h10};
        exp_v[2] = {1'b1, 1'b0, 2'd2, 64'h10};
        exp_v[3] = {1'b1, 1'b1, 2'd1, 64'h11};
        exp_v[4] = {1'b1, 1'b1, 2'd1, 64'h12};
        exp_v[5] = {1'b0, 1'b1, 2'd0, NOP};
        for (int i = 0; i < 6; i++) begin
            if (i == 3) out_ready = 1'b1;
            in_valid = i < 5;
            in_data  = i < 2 ? 64'h10 + W'(i) : 64'h12;
            tick();
            checks++;
            if ({out_valid, in_ready, occupancy, out_data} !== exp_v[i])
                $display("FAIL stall_%0d: got %h want %h", i, {out_valid, in_ready, occupancy, out_data}, exp_v[i]);
            else passed++;
        end
    endtask

    task automatic test_flush_full;
        logic [W+3:0] exp_v;
        out_ready = 1'b0;
        push(64'h40);
        push(64'h41);
        checks++;
        if (occupancy !== 2'd2) $display("FAIL flush_fill: occupancy %0d want 2", occupancy);
        else passed++;
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_v = {1'b0, 1'b1, 2'd0, NOP};
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== exp_v)
            $display("FAIL flush_full: got %h want %h", {out_valid, in_ready, occupancy, out_data}, exp_v);
        else passed++;
        out_ready = 1'b1;
        push(64'h20);
        exp_v = {1'b1, 1'b1, 2'd1, 64'h20};
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== exp_v)
            $display("FAIL flush_after: got %h want %h", {out_valid, in_ready, occupancy, out_data}, exp_v);
        else passed++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush_accept;
        logic [W+3:0] exp_v;
        out_ready = 1'b0;
        push(64'h50);
        flush = 1'b1;
        push(64'h30);
        flush = 1'b0; in_valid = 1'b0;
        exp_v = {1'b0, 1'b1, 2'd0, NOP};
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== exp_v)
            $display("FAIL flush_accept: got %h want %h", {out_valid, in_ready, occupancy, out_data}, exp_v);
        else passed++;
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== exp_v)
            $display("FAIL flush_accept_late: got %h want %h", {out_valid, in_ready, occupancy, out_data}, exp_v);
        else passed++;
    endtask

    task automatic test_reset_mid;
        logic [W+3:0] exp_v;
        out_ready = 1'b0;
        push(64'h60);
        push(64'h61);
        rst_n = 1'b0;
        push(64'h62);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        exp_v = {1'b0, 1'b1, 2'd0, NOP};
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== exp_v)
            $display("FAIL reset_mid: got %h want %h", {out_valid, in_ready, occupancy, out_data}, exp_v);
        else passed++;
        tick();
        checks++;
        if ({out_valid, in_ready, occupancy, out_data} !== exp_v)
            $display("FAIL reset_mid_after: got %h want %h", {out_valid, in_ready, occupancy, out_data}, exp_v);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_flush_full();
        test_flush_accept();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register, the successor to the fixed 32-bit enable-only stage registers between processor stages (IF/ID, ID/EX, ...). Carries an arbitrary-width payload with a valid/ready handshake, a two-entry skid buffer so `in_ready` is fully registered, a synchronous flush for branch/jump squashing, and NOP bubble insertion whenever the stage is empty. One instance sits at each pipeline boundary; the hazard unit drives `out_ready` (stall) and `flush`.

## Interface

- `DATA_W`, 64, payload width in bits (IF/ID use: `{instruction, PCp4}`).
- `NOP_VALUE`, `{DATA_W{1'b0}}`, value presented on `out_data` whenever `out_valid`=0; reset value of payload.
- `clk`  input  1  single clock; all state updates on posedge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  upstream has a payload this cycle.
- `in_ready`  output  1  stage can accept; registered, equals `!skid_valid`.
- `in_data`  input  DATA_W  upstream payload.
- `flush`  input  1  squash all held payloads.
- `out_valid`  output  1  `out_data` holds a live payload.
- `out_ready`  input  1  downstream consumes (0 = stall).
- `out_data`  output  DATA_W  payload to next stage.
- `occupancy`  output  2  entries held: 0, 1 or 2.

## Operation

- Internal state: `main_valid/main_data` (drives outputs), `skid_valid/skid_data`.
- `accept = in_valid & in_ready`; `drain = out_valid & out_ready`.
- States: EMPTY (main 0, skid 0), HALF (main 1, skid 0), FULL (main 1, skid 1). Main 0 with skid 1 is illegal and must never occur.
- EMPTY: accept -> HALF, main<=in_data. No accept -> stay.
- HALF: accept & drain -> HALF, main<=in_data. accept & !drain -> FULL, skid<=in_data. !accept & drain -> EMPTY, main_data<=NOP_VALUE. Neither -> hold.
- FULL: `in_ready`=0, so no accept. drain -> HALF, main<=skid_data, skid_data<=NOP_VALUE. No drain -> hold.
- Ordering: payloads leave in acceptance order; none duplicated, none lost except by flush.
- Flush (priority over everything except reset): next state EMPTY, both data registers <= NOP_VALUE. A handshake completing in the flush cycle (accept or drain) is honoured by the other side but its payload is discarded by this stage.
- `out_data` = NOP_VALUE whenever `out_valid`=0 (bubble insertion); downstream may consume it as a NOP.
- `occupancy` = main_valid + skid_valid.

## Timing

- Reset (`rst_n`=0 at posedge): `out_valid`=0, `out_data`=NOP_VALUE, `in_ready`=1, `occupancy`=0; skid cleared. Reset mid-transfer discards all held payloads; inputs ignored that cycle.
- Latency: payload accepted at edge N appears on `out_data` after edge N (HALF), i.e. 1 cycle, when stage not backed up.
- Throughput: 1 payload/cycle with `out_ready` held 1.
- `in_ready` drops one cycle after the second entry is captured and rises the cycle after a drain from FULL; no combinational path from `out_ready` to `in_ready`.
- `out_valid`, `out_data`, `occupancy`, `in_ready` are pure register outputs.
- `in_data` sampled only on accept; `in_valid` while `in_ready`=0 has no effect (upstream must hold).

## Test plan

- Reset: `rst_n`=0 for 2 cycles with `in_valid`=1, `in_data`=0xAAAA -> `out_valid`=0, `out_data`=NOP_VALUE, `in_ready`=1, `occupancy`=0.
- Streaming: `out_ready`=1, push 0x1..0x8 on consecutive cycles -> `out_data` shows 0x1..0x8 one cycle later, `out_valid` continuous, `in_ready` never 0.
- Stall/skid: `out_ready`=0, push 0x10, 0x11, 0x12 -> 0x10 in main, 0x11 in skid, `in_ready`=0, `occupancy`=2, 0x12 held upstream; release `out_ready` -> outputs 0x10, 0x11, 0x12 in order, no loss.
- Flush while FULL: occupancy 2, assert `flush` for 1 cycle -> next cycle `out_valid`=0, `out_data`=NOP_VALUE, `in_ready`=1, `occupancy`=0; following push 0x20 emerges normally.
- Flush with simultaneous accept: HALF, `flush`=1 and accept 0x30 same cycle -> 0x30 never appears on `out_data`.
- Bubble: HALF, drain with `in_valid`=0 -> `out_valid`=0, `out_data`=NOP_VALUE (e.g. NOP_VALUE=0x13 parameter override shows 0x13).
